rv_iommu_ls_arb: RTL and testbench
==================================

Name: rv_iommu_ls_arb

Overview:
- Shares the single memory load/store port among NREQ requesters: walker, command queue, fault queue and page-request queue.
- Round-robin arbitration between requesters.
- Remaps each requester tag onto an internal outstanding-transaction ID (ID).
- Steers load/AMO data returns back to the requester that issued the access.
- Sits between the requesters and the load/store port adapter.

Parameters:
- NREQ, 4, number of requesters; index 0 = walker.
- TAG_W, 3, width of a requester tag.
- MAX_OUT, 8, outstanding-table entries (power of 2).
- ID_W, $clog2(MAX_OUT), width of the downstream tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_ls_addr_i  in  NREQ*46  request address, packed; requester r at bits [r*46 +: 46]
- s_ls_op_i  in  NREQ*2  request op: 0 load, 1 store, 2 AMO, 3 reserved
- s_ls_tag_i  in  NREQ*TAG_W  requester tag
- s_ls_size_i  in  NREQ*7  access size
- s_ls_req_irdy_i  in  NREQ  request valid
- s_ls_req_trdy_o  out  NREQ  request accept
- s_ld_data_o  out  512  return data, broadcast to all requesters
- s_ld_acc_fault_o  out  1  access fault, broadcast
- s_ld_poison_o  out  1  poison, broadcast
- s_ld_tag_o  out  TAG_W  original requester tag
- s_ld_data_irdy_o  out  NREQ  return valid, one-hot by requester
- s_ld_data_trdy_i  in  NREQ  return accept
- m_ls_addr_o  out  46  downstream address
- m_ls_op_o  out  2  downstream op
- m_ls_tag_o  out  ID_W  downstream ID
- m_ls_size_o  out  7  downstream size
- m_ls_req_irdy_o  out  1  downstream request valid
- m_ls_req_trdy_i  in  1  downstream request accept
- m_ld_data_i  in  512  return data
- m_ld_acc_fault_i  in  1  return access fault
- m_ld_poison_i  in  1  return poison
- m_ld_tag_i  in  ID_W  return ID
- m_ld_data_irdy_i  in  1  return valid
- m_ld_data_trdy_o  out  1  return accept
- busy_o  out  1  any table entry valid, or the output register is full
- bad_tag_o  out  1  sticky flag: return seen on an unallocated ID

Behaviour:
- Handshake: a transfer occurs when irdy & trdy are both high on a rising edge. irdy must not depend on trdy.
- Output register (OR): one entry holding m_ls_*.
  - Loads when it is empty, or when it is full and m_ls_req_trdy_i is high (same-cycle reload allowed).
  - A request accepted in cycle N is presented on m_ls_* in cycle N+1.
  - OR contents are stable while m_ls_req_irdy_o=1 and m_ls_req_trdy_i=0.
- Eligibility: requester r is eligible when irdy[r]=1 and op != 3.
  - A load or AMO is also eligible only if the table has a free entry.
  - A store is always eligible. Stores do not allocate an entry; m_ls_tag_o=0 for stores.
- Reserved op (3): trdy[r] is never asserted, so the request stalls indefinitely. This is a requester bug.
- Arbitration:
  - Round-robin pointer rr holds the last granted index and resets to NREQ-1.
  - Search order is rr+1, rr+2, ... modulo NREQ.
  - At most one trdy bit is high per cycle; rr updates only on a transfer.
  - trdy is combinational from irdy, rr, the free vector and OR state.
- Table:
  - Each entry holds {valid, src[$clog2(NREQ)-1:0], tag[TAG_W-1:0]}.
  - Allocation picks the lowest-index free entry. The free vector is the registered valid state.
  - An entry freed in cycle N can be reallocated no earlier than cycle N+1.
- Return path (combinational pass-through):
  - e = table[m_ld_tag_i].
  - If e.valid: s_ld_data_irdy_o = onehot(e.src) & m_ld_data_irdy_i; s_ld_tag_o = e.tag; m_ld_data_trdy_o = s_ld_data_trdy_i[e.src].
  - The entry is cleared when the return transfer completes.
- Invalid return ID: m_ld_data_trdy_o=1, no s_ld_data_irdy_o bit asserted, data dropped, bad_tag_o set until reset.
- Simultaneous allocation and return completion: both take effect. They always target different entries, because allocation uses only entries that were free last cycle.
- Reset values:
  - m_ls_req_irdy_o=0, s_ls_req_trdy_o=0, s_ld_data_irdy_o=0, m_ld_data_trdy_o=0.
  - All table entries invalid, rr=NREQ-1, bad_tag_o=0, busy_o=0, m_ls_* data outputs=0.
- Reset mid-operation: in-flight OR contents and table entries are discarded. Returns arriving after reset hit the invalid-ID rule.

Optional Feature:
- Macro: RV_IOMMU_LS_ARB_WALKER_PRIO_EN.
  - Defined: requester 0 (walker), when eligible, wins over the round-robin order. rr is not updated on walker grants.
  - Undefined: pure round-robin as above.

Test Plan:
- All 4 requesters issue loads continuously, m_ls_req_trdy_i=1 → grants in order 0,1,2,3,0.
  - m_ls_tag_o = 0,1,2,3,4.
  - Each request appears on m_ls_* one cycle after its s-side transfer.
- 8 loads from requester 1 with no returns → the 9th load is not granted while a store from requester 2 is granted.
  - One return with ID 5 → next load allocates ID 5 one cycle after the return.
- Load from requester 2 with tag 6 → downstream ID 0. Return with ID 0, data 0xA5.. → s_ld_data_irdy_o=4'b0100, s_ld_tag_o=6.
  - With s_ld_data_trdy_i[2]=0 for 3 cycles, m_ld_data_trdy_o stays 0 and the entry stays valid.
- m_ls_req_trdy_i=0 for 5 cycles with a full OR → m_ls_* stable. All s_ls_req_trdy_o stay 0 once the OR is full.
- Return with ID 7 while entry 7 is invalid → m_ld_data_trdy_o=1, s_ld_data_irdy_o=0, bad_tag_o=1 until rst.
- Macro defined, requesters 0 and 3 always requesting → requester 0 granted every cycle.
  - Macro undefined, same stimulus → grants alternate 0,3,0,3.

Source files
------------

// File: rtl/rv_iommu_ls_arb.sv
// rv_iommu_ls_arb
// Shares one memory load/store port among NREQ requesters (index 0 = walker).
// Round-robin grant into a single output register. Load/AMO requests are
// remapped onto an outstanding-table ID. Returns are steered back to the
// issuing requester by table lookup.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_ls_*                   packed per-requester request channel (irdy/trdy)
//   s_ld_*                   return channel: data/fault/poison/tag broadcast,
//                            irdy one-hot by requester
//   m_ls_*                   downstream request channel (registered)
//   m_ld_*                   downstream return channel
//   busy_o                   any table entry valid or output register full
//   bad_tag_o                sticky: return seen on an unallocated ID
//
// Optional feature macro: RV_IOMMU_LS_ARB_WALKER_PRIO_EN
//   defined   -> an eligible walker (requester 0) beats round-robin order,
//                and walker grants leave the round-robin pointer unchanged.
//   undefined -> pure round-robin.
module rv_iommu_ls_arb #(
    parameter int NREQ    = 4,
    parameter int TAG_W   = 3,
    parameter int MAX_OUT = 8,
    parameter int ID_W    = $clog2(MAX_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*46-1:0]    s_ls_addr_i,
    input  logic [NREQ*2-1:0]     s_ls_op_i,
    input  logic [NREQ*TAG_W-1:0] s_ls_tag_i,
    input  logic [NREQ*7-1:0]     s_ls_size_i,
    input  logic [NREQ-1:0]       s_ls_req_irdy_i,
    output logic [NREQ-1:0]       s_ls_req_trdy_o,
    output logic [511:0]          s_ld_data_o,
    output logic                  s_ld_acc_fault_o,
    output logic                  s_ld_poison_o,
    output logic [TAG_W-1:0]      s_ld_tag_o,
    output logic [NREQ-1:0]       s_ld_data_irdy_o,
    input  logic [NREQ-1:0]       s_ld_data_trdy_i,
    output logic [45:0]           m_ls_addr_o,
    output logic [1:0]            m_ls_op_o,
    output logic [ID_W-1:0]       m_ls_tag_o,
    output logic [6:0]            m_ls_size_o,
    output logic                  m_ls_req_irdy_o,
    input  logic                  m_ls_req_trdy_i,
    input  logic [511:0]          m_ld_data_i,
    input  logic                  m_ld_acc_fault_i,
    input  logic                  m_ld_poison_i,
    input  logic [ID_W-1:0]       m_ld_tag_i,
    input  logic                  m_ld_data_irdy_i,
    output logic                  m_ld_data_trdy_o,
    output logic                  busy_o,
    output logic                  bad_tag_o
);

    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SRC_W:0] NREQ_V = (SRC_W+1)'(NREQ);
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    logic [45:0]      req_addr [NREQ];
    logic [1:0]       req_op   [NREQ];
    logic [TAG_W-1:0] req_tag  [NREQ];
    logic [6:0]       req_size [NREQ];

    logic [MAX_OUT-1:0] ent_valid;
    logic [SRC_W-1:0]   ent_src [MAX_OUT];
    logic [TAG_W-1:0]   ent_tag [MAX_OUT];

    logic [SRC_W-1:0] rr;
    logic             or_valid;

    logic [NREQ-1:0]  elig;
    logic             free_any;
    logic             grant_found;
    logic             prio_grant;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   cand;
    logic             or_can_load;
    logic             req_fire;
    logic             g_alloc;
    logic [ID_W-1:0]  alloc_idx;

    logic             e_valid;
    logic [SRC_W-1:0] e_src;
    logic             ret_fire;

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            req_addr[r] = s_ls_addr_i[r*46 +: 46];
            req_op[r]   = s_ls_op_i[r*2 +: 2];
            req_tag[r]  = s_ls_tag_i[r*TAG_W +: TAG_W];
            req_size[r] = s_ls_size_i[r*7 +: 7];
        end
    end

    // Eligibility uses the registered valid vector, so an entry freed this
    // cycle is only reusable from the next cycle on.
    assign free_any = ~&ent_valid;

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            elig[r] = s_ls_req_irdy_i[r] && (req_op[r] != OP_RSVD) &&
                      ((req_op[r] == OP_STORE) || free_any);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        prio_grant  = 1'b0;
        grant_idx   = rr;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr} + (SRC_W+1)'(k);
            if (cand >= NREQ_V) cand = cand - NREQ_V;
            if (!grant_found && elig[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
`ifdef RV_IOMMU_LS_ARB_WALKER_PRIO_EN
        if (elig[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
            prio_grant  = 1'b1;
        end
`endif
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = MAX_OUT-1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_idx = ID_W'(i);
        end
    end

    assign or_can_load     = !or_valid || m_ls_req_trdy_i;
    assign req_fire        = grant_found && or_can_load && !rst;
    assign s_ls_req_trdy_o = req_fire ? (NREQ'(1) << grant_idx) : '0;
    assign g_alloc         = req_op[grant_idx] != OP_STORE;

    assign m_ls_req_irdy_o = or_valid;
    assign busy_o          = (|ent_valid) || or_valid;

    // Return path: combinational lookup on the returned ID.
    assign e_valid          = ent_valid[m_ld_tag_i];
    assign e_src            = ent_src[m_ld_tag_i];
    assign s_ld_data_o      = m_ld_data_i;
    assign s_ld_acc_fault_o = m_ld_acc_fault_i;
    assign s_ld_poison_o    = m_ld_poison_i;
    assign s_ld_tag_o       = e_valid ? ent_tag[m_ld_tag_i] : '0;
    assign s_ld_data_irdy_o = (!rst && e_valid && m_ld_data_irdy_i) ? (NREQ'(1) << e_src) : '0;
    // Unknown IDs are always accepted so a stray return can never wedge the port.
    assign m_ld_data_trdy_o = rst ? 1'b0 : (e_valid ? s_ld_data_trdy_i[e_src] : 1'b1);
    assign ret_fire         = m_ld_data_irdy_i && m_ld_data_trdy_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid    <= 1'b0;
            m_ls_addr_o <= '0;
            m_ls_op_o   <= '0;
            m_ls_tag_o  <= '0;
            m_ls_size_o <= '0;
            rr          <= SRC_W'(NREQ-1);
            ent_valid   <= '0;
            bad_tag_o   <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                ent_src[i] <= '0;
                ent_tag[i] <= '0;
            end
        end else begin
            if (or_can_load) begin
                or_valid <= req_fire;
                if (req_fire) begin
                    m_ls_addr_o <= req_addr[grant_idx];
                    m_ls_op_o   <= req_op[grant_idx];
                    m_ls_size_o <= req_size[grant_idx];
                    m_ls_tag_o  <= g_alloc ? alloc_idx : '0;
                end
            end
            if (req_fire && !prio_grant) rr <= grant_idx;

            // Free and allocate never collide: allocation only uses entries
            // that were already free in the registered state.
            if (ret_fire && e_valid) ent_valid[m_ld_tag_i] <= 1'b0;
            if (req_fire && g_alloc) begin
                ent_valid[alloc_idx] <= 1'b1;
                ent_src[alloc_idx]   <= grant_idx;
                ent_tag[alloc_idx]   <= req_tag[grant_idx];
            end

            if (m_ld_data_irdy_i && !e_valid) bad_tag_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_iommu_ls_arb.sv
module tb_rv_iommu_ls_arb;

    localparam int NREQ    = 4;
    localparam int TAG_W   = 3;
    localparam int MAX_OUT = 8;
    localparam int ID_W    = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ*46-1:0]    s_ls_addr_i;
    logic [NREQ*2-1:0]     s_ls_op_i;
    logic [NREQ*TAG_W-1:0] s_ls_tag_i;
    logic [NREQ*7-1:0]     s_ls_size_i;
    logic [NREQ-1:0]       s_ls_req_irdy_i;
    logic [NREQ-1:0]       s_ls_req_trdy_o;
    logic [511:0]          s_ld_data_o;
    logic                  s_ld_acc_fault_o;
    logic                  s_ld_poison_o;
    logic [TAG_W-1:0]      s_ld_tag_o;
    logic [NREQ-1:0]       s_ld_data_irdy_o;
    logic [NREQ-1:0]       s_ld_data_trdy_i;
    logic [45:0]           m_ls_addr_o;
    logic [1:0]            m_ls_op_o;
    logic [ID_W-1:0]       m_ls_tag_o;
    logic [6:0]            m_ls_size_o;
    logic                  m_ls_req_irdy_o;
    logic                  m_ls_req_trdy_i;
    logic [511:0]          m_ld_data_i;
    logic                  m_ld_acc_fault_i;
    logic                  m_ld_poison_i;
    logic [ID_W-1:0]       m_ld_tag_i;
    logic                  m_ld_data_irdy_i;
    logic                  m_ld_data_trdy_o;
    logic                  busy_o;
    logic                  bad_tag_o;

    int n_chk = 0;
    int n_err = 0;

    rv_iommu_ls_arb #(.NREQ(NREQ), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_ls_addr_i      (s_ls_addr_i),
        .s_ls_op_i        (s_ls_op_i),
        .s_ls_tag_i       (s_ls_tag_i),
        .s_ls_size_i      (s_ls_size_i),
        .s_ls_req_irdy_i  (s_ls_req_irdy_i),
        .s_ls_req_trdy_o  (s_ls_req_trdy_o),
        .s_ld_data_o      (s_ld_data_o),
        .s_ld_acc_fault_o (s_ld_acc_fault_o),
        .s_ld_poison_o    (s_ld_poison_o),
        .s_ld_tag_o       (s_ld_tag_o),
        .s_ld_data_irdy_o (s_ld_data_irdy_o),
        .s_ld_data_trdy_i (s_ld_data_trdy_i),
        .m_ls_addr_o      (m_ls_addr_o),
        .m_ls_op_o        (m_ls_op_o),
        .m_ls_tag_o       (m_ls_tag_o),
        .m_ls_size_o      (m_ls_size_o),
        .m_ls_req_irdy_o  (m_ls_req_irdy_o),
        .m_ls_req_trdy_i  (m_ls_req_trdy_i),
        .m_ld_data_i      (m_ld_data_i),
        .m_ld_acc_fault_i (m_ld_acc_fault_i),
        .m_ld_poison_i    (m_ld_poison_i),
        .m_ld_tag_i       (m_ld_tag_i),
        .m_ld_data_irdy_i (m_ld_data_irdy_i),
        .m_ld_data_trdy_o (m_ld_data_trdy_o),
        .busy_o           (busy_o),
        .bad_tag_o        (bad_tag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] exp_addr(input int r, input int tag);
        return 46'(32'h0004_0000 + r * 256 + tag);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic on, input logic [1:0] op, input int tag);
        s_ls_req_irdy_i[r]        = on;
        s_ls_op_i[r*2 +: 2]       = op;
        s_ls_tag_i[r*TAG_W +: TAG_W] = TAG_W'(tag);
        s_ls_addr_i[r*46 +: 46]   = exp_addr(r, tag);
        s_ls_size_i[r*7 +: 7]     = 7'(r + 1);
    endtask

    task automatic clear_inputs();
        s_ls_addr_i      = '0;
        s_ls_op_i        = '0;
        s_ls_tag_i       = '0;
        s_ls_size_i      = '0;
        s_ls_req_irdy_i  = '0;
        s_ld_data_trdy_i = '0;
        m_ls_req_trdy_i  = 1'b1;
        m_ld_data_i      = '0;
        m_ld_acc_fault_i = 1'b0;
        m_ld_poison_i    = 1'b0;
        m_ld_tag_i       = '0;
        m_ld_data_irdy_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        chk("rst_m_irdy", m_ls_req_irdy_o, 0);
        chk("rst_s_trdy", s_ls_req_trdy_o, 0);
        chk("rst_m_ld_trdy", m_ld_data_trdy_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_bad_tag", bad_tag_o, 0);
        chk("rst_m_addr", m_ls_addr_o, 0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // round-robin over four loading requesters
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 2'd0, r);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", s_ls_req_trdy_o, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk("rr_m_irdy", m_ls_req_irdy_o, 1);
                chk("rr_m_tag", m_ls_tag_o, k - 1);
                chk("rr_m_addr", m_ls_addr_o, exp_addr((k - 1) % 4, (k - 1) % 4));
            end
            cyc();
        end
        s_ls_req_irdy_i = '0;
        #1;
        chk("rr_m_tag_last", m_ls_tag_o, 4);
        chk("rr_m_addr_last", m_ls_addr_o, exp_addr(0, 0));

        // fill the table, then a store still goes through
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b1, 2'd0, i);
            #1;
            chk("fill_grant", s_ls_req_trdy_o, 4'b0010);
            cyc();
        end
        set_req(1, 1'b1, 2'd0, 0);
        set_req(2, 1'b1, 2'd1, 3);
        #1;
        chk("full_store_grant", s_ls_req_trdy_o, 4'b0100);
        chk("full_busy", busy_o, 1);
        cyc();
        chk("store_op", m_ls_op_o, 1);
        chk("store_tag", m_ls_tag_o, 0);
        chk("store_addr", m_ls_addr_o, exp_addr(2, 3));
        set_req(2, 1'b0, 2'd1, 3);
        #1;
        chk("full_load_blocked", s_ls_req_trdy_o, 0);
        m_ld_data_irdy_i = 1'b1;
        m_ld_tag_i       = 3'd5;
        s_ld_data_trdy_i = 4'hF;
        #1;
        chk("ret5_irdy", s_ld_data_irdy_o, 4'b0010);
        chk("ret5_tag", s_ld_tag_o, 5);
        chk("ret5_trdy", m_ld_data_trdy_o, 1);
        chk("ret5_no_same_cycle_alloc", s_ls_req_trdy_o, 0);
        cyc();
        m_ld_data_irdy_i = 1'b0;
        #1;
        chk("realloc_grant", s_ls_req_trdy_o, 4'b0010);
        cyc();
        set_req(1, 1'b0, 2'd0, 0);
        chk("realloc_id", m_ls_tag_o, 5);
        chk("realloc_addr", m_ls_addr_o, exp_addr(1, 0));

        // return steering with back-pressure from the requester
        do_reset();
        set_req(2, 1'b1, 2'd0, 6);
        #1;
        chk("r2_grant", s_ls_req_trdy_o, 4'b0100);
        cyc();
        set_req(2, 1'b0, 2'd0, 6);
        chk("r2_id", m_ls_tag_o, 0);
        m_ld_data_i      = {16{32'hA5A5_A5A5}};
        m_ld_tag_i       = 3'd0;
        m_ld_data_irdy_i = 1'b1;
        s_ld_data_trdy_i = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_irdy", s_ld_data_irdy_o, 4'b0100);
            chk("bp_tag", s_ld_tag_o, 6);
            chk("bp_trdy", m_ld_data_trdy_o, 0);
            chk("bp_data", s_ld_data_o, {16{32'hA5A5_A5A5}});
            cyc();
        end
        s_ld_data_trdy_i = 4'b0100;
        #1;
        chk("bp_release_irdy", s_ld_data_irdy_o, 4'b0100);
        chk("bp_release_trdy", m_ld_data_trdy_o, 1);
        cyc();
        m_ld_data_irdy_i = 1'b0;
        #1;
        chk("bp_entry_freed", busy_o, 0);
        chk("bp_no_bad_tag", bad_tag_o, 0);

        // downstream stall holds the output register
        do_reset();
        m_ls_req_trdy_i = 1'b0;
        set_req(0, 1'b1, 2'd0, 1);
        set_req(3, 1'b1, 2'd0, 2);
        #1;
        chk("stall_first_grant", s_ls_req_trdy_o, 4'b0001);
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_m_irdy", m_ls_req_irdy_o, 1);
            chk("stall_m_addr", m_ls_addr_o, exp_addr(0, 1));
            chk("stall_m_tag", m_ls_tag_o, 0);
            chk("stall_s_trdy", s_ls_req_trdy_o, 0);
            cyc();
        end
        m_ls_req_trdy_i = 1'b1;
        #1;
        chk("stall_reload_grant", s_ls_req_trdy_o, 4'b1000);
        cyc();
        s_ls_req_irdy_i = '0;
        chk("stall_reload_addr", m_ls_addr_o, exp_addr(3, 2));
        chk("stall_reload_tag", m_ls_tag_o, 1);

        // reserved op and unallocated return ID
        do_reset();
        set_req(1, 1'b1, 2'd3, 2);
        #1;
        chk("rsvd_no_grant", s_ls_req_trdy_o, 0);
        m_ld_data_irdy_i = 1'b1;
        m_ld_tag_i       = 3'd7;
        #1;
        chk("bad_trdy", m_ld_data_trdy_o, 1);
        chk("bad_s_irdy", s_ld_data_irdy_o, 0);
        chk("bad_not_yet", bad_tag_o, 0);
        cyc();
        m_ld_data_irdy_i = 1'b0;
        s_ls_req_irdy_i  = '0;
        #1;
        chk("bad_set", bad_tag_o, 1);
        cyc();
        cyc();
        chk("bad_sticky", bad_tag_o, 1);
        do_reset();

        // walker against requester 3
        set_req(0, 1'b1, 2'd0, 0);
        set_req(3, 1'b1, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef RV_IOMMU_LS_ARB_WALKER_PRIO_EN
            chk("prio_grant", s_ls_req_trdy_o, 4'b0001);
`else
            chk("alt_grant", s_ls_req_trdy_o, (k % 2 == 0) ? 4'b0001 : 4'b1000);
`endif
            cyc();
        end
        s_ls_req_irdy_i = '0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
